// File: rtl/mac_mdc_tcdm_mux.sv
// Round-robin merge of MP TCDM master ports onto one downstream port.
// A FIFO of granted port indices routes each response back in grant order.
module mac_mdc_tcdm_lane #(
  parameter int LANE = 0,
  parameter int SW   = 2
) (
  input  logic [SW-1:0] sel,
  input  logic [SW-1:0] head,
  input  logic          hs,
  input  logic          pop,
  output logic          gnt,
  output logic          r_valid
);
  assign gnt     = hs  && (sel  == SW'(LANE));
  assign r_valid = pop && (head == SW'(LANE));
endmodule

module mac_mdc_tcdm_mux #(
  parameter int MP    = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [MP-1:0]                in_req,
  output logic [MP-1:0]                in_gnt,
  input  logic [MP-1:0][31:0]          in_add,
  input  logic [MP-1:0]                in_wen,
  input  logic [MP-1:0][3:0]           in_be,
  input  logic [MP-1:0][31:0]          in_data,
  output logic [MP-1:0][31:0]          in_r_data,
  output logic [MP-1:0]                in_r_valid,
  output logic                         out_req,
  input  logic                         out_gnt,
  output logic [31:0]                  out_add,
  output logic                         out_wen,
  output logic [3:0]                   out_be,
  output logic [31:0]                  out_data,
  input  logic [31:0]                  out_r_data,
  input  logic                         out_r_valid,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         err_o
);
  localparam int SW = $clog2(MP);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [SW-1:0] rr_ptr, sel, idx, head;
  logic [SW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          any, full, hs, pop, err_q;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < MP; i++) begin
      idx = SW'((int'(rr_ptr) + i) % MP);
      if (!any && in_req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

  assign full     = (cnt == CW'(DEPTH));
  assign out_req  = any && !full && !rst_i;
  assign hs       = out_req && out_gnt;
  assign head     = mem[rd_ptr];
  assign pop      = out_r_valid && (cnt != '0) && !rst_i;

  assign out_add  = in_add[sel];
  assign out_wen  = in_wen[sel];
  assign out_be   = in_be[sel];
  assign out_data = in_data[sel];

  assign in_r_data     = {MP{out_r_data}};
  assign outstanding_o = cnt;
  assign err_o         = err_q;

  for (genvar g = 0; g < MP; g++) begin : g_lane
    mac_mdc_tcdm_lane #(.LANE(g), .SW(SW)) u_lane (
      .sel     (sel),
      .head    (head),
      .hs      (hs),
      .pop     (pop),
      .gnt     (in_gnt[g]),
      .r_valid (in_r_valid[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (hs) mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (hs) begin
        wr_ptr <= wr_ptr + PW'(1);
        rr_ptr <= (sel == SW'(MP-1)) ? '0 : sel + SW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      // A response with nothing outstanding is a protocol error.
      if (out_r_valid && cnt == '0) err_q <= 1'b1;
      case ({hs, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_mdc_tcdm_mux.sv
// Directed scenarios plus a randomized run against a queue-based model
// of the round-robin merge and in-order response routing.
module tb_mac_mdc_tcdm_mux;
  localparam int MP = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic [MP-1:0] in_req, in_gnt, in_wen, in_r_valid;
  logic [MP-1:0][31:0] in_add, in_data, in_r_data;
  logic [MP-1:0][3:0] in_be;
  logic out_req, out_gnt, out_wen, out_r_valid, err;
  logic [31:0] out_add, out_data, out_r_data;
  logic [3:0] out_be;
  logic [$clog2(DEPTH+1)-1:0] outstanding;

  int total = 0, bad = 0;
  int q[$];
  int rr = 0;
  bit merr = 0;

  mac_mdc_tcdm_mux #(.MP(MP), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add),
    .in_wen(in_wen), .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data),
    .in_r_valid(in_r_valid), .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add),
    .out_wen(out_wen), .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data),
    .out_r_valid(out_r_valid), .outstanding_o(outstanding), .err_o(err));

  always #5 clk = ~clk;

  // Model: selected port by the round-robin rule, or -1.
  function automatic int msel();
    for (int i = 0; i < MP; i++) if (in_req[(rr + i) % MP]) return (rr + i) % MP;
    return -1;
  endfunction

  function automatic bit mreq();
    return !rst && msel() >= 0 && q.size() < DEPTH;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    bit r;
    int s;
    r = mreq();
    s = msel();
    if (rst) begin
      q.delete(); rr = 0; merr = 0;
    end else begin
      if (out_r_valid) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1;
      end
      if (r && out_gnt) begin q.push_back(s); rr = (s + 1) % MP; end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_req = '0; in_wen = '1; in_be = '1; out_gnt = 1'b0; out_r_valid = 1'b0;
    out_r_data = '0;
    for (int p = 0; p < MP; p++) begin
      in_add[p] = 32'h1000 * (p + 1); in_data[p] = 32'hA0 + p;
    end
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0; #2;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; in_req = '1; out_gnt = 1'b1; out_r_valid = 1'b1; #2;
    total++; if (out_req !== 1'b0) begin bad++; $display("FAIL reset_out_req got=%b want=0", out_req); end
    total++; if (in_gnt !== '0) begin bad++; $display("FAIL reset_gnt got=%b want=0", in_gnt); end
    total++; if (in_r_valid !== '0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", in_r_valid); end
    tick(); rst = 1'b0; idle(); #2;
    total++; if (outstanding !== 0) begin bad++; $display("FAIL reset_outst got=%0d want=0", outstanding); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_single_port();
    do_reset();
    in_req = 4'b0100; in_add[2] = 32'h100; out_gnt = 1'b1; #2;
    total++; if (in_gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", in_gnt); end
    total++; if (out_add !== 32'h100) begin bad++; $display("FAIL single_add got=%h want=100", out_add); end
    tick(); idle(); tick();
    out_r_valid = 1'b1; out_r_data = 32'hDEADBEEF; #2;
    total++; if (in_r_valid !== 4'b0100) begin bad++; $display("FAIL single_rvalid got=%b want=0100", in_r_valid); end
    total++; if (in_r_data[2] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h want=deadbeef", in_r_data[2]); end
    tick(); idle();
  endtask

  task automatic test_round_robin();
    do_reset();
    in_req = '1; out_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_r_valid = (i > 0); #2;
      total++; if (in_gnt !== MP'(1 << (i % MP))) begin bad++; $display("FAIL rr_gnt[%0d] got=%b want=%b", i, in_gnt, MP'(1 << (i % MP))); end
      if (i > 0) begin
        total++; if (in_r_valid !== MP'(1 << ((i - 1) % MP))) begin bad++; $display("FAIL rr_rvalid[%0d] got=%b", i, in_r_valid); end
        total++; if (outstanding !== 1) begin bad++; $display("FAIL rr_outst[%0d] got=%0d want=1", i, outstanding); end
      end
      tick();
    end
    idle(); out_r_valid = 1'b1; tick(); idle(); #2;
    total++; if (outstanding !== 0) begin bad++; $display("FAIL rr_drain got=%0d want=0", outstanding); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_req = 4'b0001; out_gnt = 1'b1; tick();
    in_req = 4'b1011; out_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (in_gnt !== '0) begin bad++; $display("FAIL bp_gnt[%0d] got=%b want=0", i, in_gnt); end
      total++; if (out_add !== in_add[1]) begin bad++; $display("FAIL bp_add[%0d] got=%h want=%h", i, out_add, in_add[1]); end
      tick();
    end
    out_gnt = 1'b1; #2;
    total++; if (in_gnt !== 4'b0010) begin bad++; $display("FAIL bp_release got=%b want=0010", in_gnt); end
    tick(); in_req = '1; #2;
    total++; if (in_gnt !== 4'b0100) begin bad++; $display("FAIL bp_next got=%b want=0100", in_gnt); end
    tick(); idle(); #2;
    total++; if (outstanding !== 3) begin bad++; $display("FAIL bp_outst got=%0d want=3", outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    in_req = '1; out_gnt = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    #2;
    total++; if (out_req !== 1'b0) begin bad++; $display("FAIL full_req got=%b want=0", out_req); end
    total++; if (outstanding !== DEPTH) begin bad++; $display("FAIL full_outst got=%0d want=%0d", outstanding, DEPTH); end
    out_r_valid = 1'b1; #1;
    total++; if (out_req !== 1'b0) begin bad++; $display("FAIL full_pop_req got=%b want=0", out_req); end
    total++; if (in_r_valid !== 4'b0001) begin bad++; $display("FAIL full_head got=%b want=0001", in_r_valid); end
    tick(); out_r_valid = 1'b0; #2;
    total++; if (out_req !== 1'b1) begin bad++; $display("FAIL full_reopen got=%b want=1", out_req); end
    total++; if (outstanding !== DEPTH - 1) begin bad++; $display("FAIL full_outst2 got=%0d", outstanding); end
    tick(); idle(); out_r_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    idle(); #2;
    total++; if (outstanding !== 0) begin bad++; $display("FAIL full_drain got=%0d want=0", outstanding); end
  endtask

  task automatic test_err_reset();
    do_reset();
    out_r_valid = 1'b1; #2;
    total++; if (in_r_valid !== '0) begin bad++; $display("FAIL err_rvalid got=%b want=0", in_r_valid); end
    tick(); out_r_valid = 1'b0; #2;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", err); end
    in_req = 4'b0011; out_gnt = 1'b1; tick(); tick(); idle(); #2;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    total++; if (outstanding !== 2) begin bad++; $display("FAIL err_outst got=%0d want=2", outstanding); end
    rst = 1'b1; tick(); rst = 1'b0; #2;
    total++; if (outstanding !== 0) begin bad++; $display("FAIL rst_outst got=%0d want=0", outstanding); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    out_r_valid = 1'b1; tick(); out_r_valid = 1'b0; #2;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL stale_rsp_err got=%b want=1", err); end
  endtask

  task automatic test_random();
    logic [MP-1:0] eg, ev;
    int s, p;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      in_req = MP'($urandom);
      out_gnt = ($urandom_range(0, 3) != 0);
      out_r_valid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      out_r_data = $urandom;
      for (int k = 0; k < MP; k++) begin
        in_add[k] = $urandom; in_data[k] = $urandom; in_be[k] = 4'($urandom); in_wen[k] = 1'($urandom);
      end
      #2;
      s = msel();
      eg = (mreq() && out_gnt) ? MP'(1 << s) : '0;
      ev = (!rst && out_r_valid && q.size() > 0) ? MP'(1 << q[0]) : '0;
      total++; if (out_req !== mreq()) begin bad++; $display("FAIL rnd_req[%0d] got=%b want=%b", n, out_req, mreq()); end
      total++; if (in_gnt !== eg) begin bad++; $display("FAIL rnd_gnt[%0d] got=%b want=%b", n, in_gnt, eg); end
      if (s >= 0) begin
        total++; if ({out_add, out_data, out_be, out_wen} !== {in_add[s], in_data[s], in_be[s], in_wen[s]})
          begin bad++; $display("FAIL rnd_mux[%0d] got=%h want=%h", n, out_add, in_add[s]); end
      end
      total++; if (in_r_valid !== ev) begin bad++; $display("FAIL rnd_rvalid[%0d] got=%b want=%b", n, in_r_valid, ev); end
      p = $urandom_range(0, MP - 1);
      total++; if (in_r_data[p] !== out_r_data) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", n, in_r_data[p], out_r_data); end
      total++; if (outstanding !== q.size()) begin bad++; $display("FAIL rnd_outst[%0d] got=%0d want=%0d", n, outstanding, q.size()); end
      total++; if (err !== merr) begin bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", n, err, merr); end
      tick();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_full();
    test_err_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
